input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 50000: cycles a synchronized input must differ from its stable value before it is accepted; legal range >= 1.
- REPEAT_DELAY, 25000000: cycles the key must be held after the press step before the first auto-repeat step; legal range >= 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat steps; legal range >= 1.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1: single system clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- key_raw, in, 1: raw push button; active-low, 0 = pressed; asynchronous to clock.
- switch_raw, in, 4: raw slide switches; asynchronous to clock.
- repeat_en, in, 1: synchronous level that enables auto-repeat.
- switch, out, 4: debounced, synchronized switch value.
- switch_changed, out, 1: one-cycle pulse when switch changes.
- key_held, out, 1: debounced key level; 1 = pressed.
- key_press, out, 1: one-cycle pulse on a debounced press.
- key_release, out, 1: one-cycle pulse on a debounced release.
- key_step, out, 1: one-cycle step pulse; fires on press and on each auto-repeat.

Function
REQ-003 Each of the 5 raw bits SHALL pass through its own 2-flop synchronizer; no raw bit feeds logic other than the first flop.
REQ-004 Each bit SHALL own an independent debounce counter of width clog2(DEBOUNCE_CYCLES)+1 bits, paired with a stable register.
REQ-005 On each edge where the synchronized bit equals its stable value, the counter SHALL clear to 0.
REQ-006 On each edge where the synchronized bit differs from its stable value and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-007 On an edge where the synchronized bit differs and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-008 Latency: for a raw change held steady, with the first capturing edge numbered edge 1, the stable value SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-009 A glitch that reverts before acceptance SHALL restart that bit's count from 0 and SHALL NOT change any output.
REQ-010 switch SHALL equal the 4 stable switch bits.
REQ-011 key_held SHALL equal the inverse of the stable key bit.
REQ-012 switch_changed, key_press and key_release SHALL be registered.
- Each asserts for exactly one cycle, starting after the edge that updates the corresponding stable value.
- Simultaneous changes on several switch bits produce a single switch_changed pulse.
REQ-013 The repeat FSM SHALL have 3 states.
- IDLE -> DELAY on key_press.
- DELAY -> REPEAT when the repeat counter reaches REPEAT_DELAY-1 and repeat_en=1.
- REPEAT re-arms every REPEAT_PERIOD cycles.
- Any state -> IDLE on key_release.
REQ-014 key_step SHALL pulse for one cycle together with key_press.
- It also pulses on the DELAY->REPEAT transition and on each REPEAT re-arm.
- It never pulses in the same cycle as key_release.
REQ-015 In DELAY or REPEAT with repeat_en=0, the FSM SHALL hold its state and counter and issue no steps.
- When repeat_en returns to 1, counting resumes from the held value.
REQ-016 The repeat counter SHALL clear on every state transition and SHALL never wrap.

Reset
REQ-017 reset=0 SHALL immediately, without a clock edge, set the following.
- Synchronizers and stable registers to released/0: key bits 1, switch bits 0.
- All counters to 0.
- FSM to IDLE.
- All outputs to 0.
REQ-018 After reset deasserts, raw inputs already active SHALL be reported under REQ-008 timing, counted from the first edge after deassertion.
REQ-019 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse is issued on reset entry or exit.

Verification
Scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
REQ-020 switch_raw 0->4'b1010, held steady -> switch=4'b1010 after edge 6; one switch_changed pulse.
REQ-021 key_raw low for 3 cycles then high -> no key_held, key_press or key_step; counter back at 0.
REQ-022 key_raw low, held 40 cycles, repeat_en=1.
- key_press and key_step together after edge 6.
- Further key_step pulses 10 cycles later, then every 3 cycles.
- On release: key_release pulse, and the FSM returns to IDLE.
REQ-023 Same as REQ-022 but repeat_en=0 from cycle 12 to 20 -> no key_step during that window; repeat timing resumes from the held count.
REQ-024 reset pulsed low during a switch debounce at count 2 -> all outputs 0 immediately; the held input is accepted 6 edges after deassertion.
REQ-025 switch_raw bits 0 and 3 change in the same cycle -> both bits update at the same edge; exactly one switch_changed pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one active-low key and four slide switches,
// with an auto-repeat step generator on the debounced key.
//
// state    | meaning
// S_IDLE   | key released, no repeat activity
// S_DELAY  | key held, counting towards the first auto-repeat step
// S_REPEAT | key held, issuing a step every REPEAT_PERIOD cycles
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_raw,
  input  logic [3:0] switch_raw,
  input  logic       repeat_en,
  output logic [3:0] switch,
  output logic       switch_changed,
  output logic       key_held,
  output logic       key_press,
  output logic       key_release,
  output logic       key_step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  // bit 4 is the key (idle high), bits 3:0 are the switches (idle low)
  localparam logic [4:0]    IDLE_LEVEL  = 5'b1_0000;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [4:0]    raw, sync1, sync2, stable, differ, accept;
  logic [DW-1:0] db_cnt [5];
  logic          press_evt, release_evt, step_evt;
  state_t        state, state_nxt;
  logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;

  assign raw = {key_raw, switch_raw};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign differ = sync2 ^ stable;

  always_comb begin
    accept = '0;
    for (int i = 0; i < 5; i++) begin
      accept[i] = differ[i] && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= IDLE_LEVEL;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!differ[i] || accept[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
      stable <= stable ^ accept;
    end
  end

  assign press_evt   = accept[4] && !sync2[4];
  assign release_evt = accept[4] &&  sync2[4];

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    step_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_evt) begin
          state_nxt   = S_DELAY;
          rpt_cnt_nxt = '0;
          step_evt    = 1'b1;
        end
      end
      S_DELAY: begin
        if (repeat_en) begin
          if (rpt_cnt == DELAY_LAST) begin
            state_nxt   = S_REPEAT;
            rpt_cnt_nxt = '0;
            step_evt    = 1'b1;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
      end
      S_REPEAT: begin
        if (repeat_en) begin
          if (rpt_cnt == PERIOD_LAST) begin
            rpt_cnt_nxt = '0;
            step_evt    = 1'b1;
          end else begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
          end
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        rpt_cnt_nxt = '0;
      end
    endcase
    // a release overrides any step that would coincide with it
    if (release_evt) begin
      state_nxt   = S_IDLE;
      rpt_cnt_nxt = '0;
      step_evt    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      switch_changed <= 1'b0;
      key_press      <= 1'b0;
      key_release    <= 1'b0;
      key_step       <= 1'b0;
    end else begin
      switch_changed <= |accept[3:0];
      key_press      <= press_evt;
      key_release    <= release_evt;
      key_step       <= step_evt;
    end
  end

  assign switch   = stable[3:0];
  assign key_held = ~stable[4];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever any output pulse is seen.
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_raw;
  logic [3:0] switch_raw;
  logic       repeat_en;
  logic [3:0] switch;
  logic       switch_changed, key_held, key_press, key_release, key_step;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_raw       (key_raw),
    .switch_raw    (switch_raw),
    .repeat_en     (repeat_en),
    .switch        (switch),
    .switch_changed(switch_changed),
    .key_held      (key_held),
    .key_press     (key_press),
    .key_release   (key_release),
    .key_step      (key_step)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // mask bits: [3] switch_changed, [2] key_press, [1] key_release, [0] key_step
  typedef struct {
    int         at;
    logic [3:0] mask;
    logic [3:0] sw;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_on   = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic void push_exp(input int at, input logic [3:0] mask, input logic [3:0] sw);
    ev_t e;
    e.at   = at;
    e.mask = mask;
    e.sw   = sw;
    exp_q.push_back(e);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    ev_t        e;
    logic [3:0] m;
    if (mon_on) begin
      m = {switch_changed, key_press, key_release, key_step};
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL missed_pulse: got nothing at cycle %0d, required mask %b", e.at, e.mask);
      end
      if (m != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got mask %b at cycle %0d, required none", m, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.at);
          check("pulse_mask", int'(m), int'(e.mask));
          check("pulse_switch", int'(switch), int'(e.sw));
        end
      end
    end
  end

  initial begin
    int b;
    key_raw    = 1'b1;
    switch_raw = 4'b0000;
    repeat_en  = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_switch", int'(switch), 0);
    check("rst_pulses", int'({switch_changed, key_press, key_release, key_step}), 0);
    check("rst_key_held", int'(key_held), 0);
    #10 reset = 1'b1;
    mon_on = 1'b1;
    cycles(2);

    // switch 0 -> 1010, accepted after edge 6
    b = cyc;
    switch_raw = 4'b1010;
    push_exp(b + 6, 4'b1000, 4'b1010);
    cycles(5);
    check("sw_edge5", int'(switch), 0);
    cycles(1);
    check("sw_edge6", int'(switch), 4'b1010);
    cycles(4);

    // bits 0 and 3 flip together: one pulse, same edge
    b = cyc;
    switch_raw = 4'b0011;
    push_exp(b + 6, 4'b1000, 4'b0011);
    cycles(5);
    check("sw2_edge5", int'(switch), 4'b1010);
    cycles(1);
    check("sw2_edge6", int'(switch), 4'b0011);
    cycles(4);

    // 3-cycle key glitch must be rejected
    key_raw = 1'b0;
    cycles(3);
    key_raw = 1'b1;
    cycles(10);
    check("glitch_key_held", int'(key_held), 0);

    // held key with auto-repeat; step at 46 would clash with the release
    b = cyc;
    key_raw = 1'b0;
    push_exp(b + 6, 4'b0101, 4'b0011);
    for (int k = 16; k <= 43; k += 3) push_exp(b + k, 4'b0001, 4'b0011);
    push_exp(b + 46, 4'b0010, 4'b0011);
    cycles(6);
    check("held_after_press", int'(key_held), 1);
    cycles(34);
    key_raw = 1'b1;
    cycles(6);
    check("held_after_release", int'(key_held), 0);
    cycles(8);

    // repeat_en low over edges 13..20 stretches the delay by 8
    b = cyc;
    key_raw = 1'b0;
    push_exp(b + 6, 4'b0101, 4'b0011);
    for (int k = 24; k <= 45; k += 3) push_exp(b + k, 4'b0001, 4'b0011);
    push_exp(b + 46, 4'b0010, 4'b0011);
    cycles(12);
    repeat_en = 1'b0;
    cycles(8);
    repeat_en = 1'b1;
    cycles(20);
    key_raw = 1'b1;
    cycles(14);

    // reset in the middle of a switch debounce (count 2)
    switch_raw = 4'b1100;
    cycles(4);
    #2 reset = 1'b0;
    #1;
    check("midrst_switch", int'(switch), 0);
    check("midrst_pulses", int'({switch_changed, key_press, key_release, key_step}), 0);
    check("midrst_key_held", int'(key_held), 0);
    @(posedge clock);
    #2 reset = 1'b1;
    b = cyc;
    push_exp(b + 6, 4'b1000, 4'b1100);
    cycles(5);
    check("postrst_edge5", int'(switch), 0);
    cycles(1);
    check("postrst_edge6", int'(switch), 4'b1100);
    cycles(6);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
